// File: rtl/furv_mem_responder.sv
// Data-memory responder for the furv core load/store port: captures one request,
// waits LATENCY cycles, commits a byte-enabled store or a full-word load, pulses ack.
module furv_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem,
  input  logic        mem_write,
  input  logic [29:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  addr_q;
  logic [3:0]     sel_q;
  logic [31:0]    wdata_q;
  logic           wr_q;
  logic [31:0]    rdata_q;
  logic           ack_q;
  logic           capture;
  logic           commit;
  logic [AW-1:0]  acc_addr;
  logic [3:0]     acc_sel;
  logic [31:0]    acc_wdata;
  logic           acc_wr;
  logic           unused_addr;

  logic [31:0] ram [DEPTH];

  initial for (int unsigned i = 0; i < DEPTH; i++) ram[i] = '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem) begin
          capture = 1'b1;
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With LATENCY=0 the commit edge is the capture edge, so take the live inputs.
  assign acc_addr  = capture ? addr[AW-1:0] : addr_q;
  assign acc_sel   = capture ? sel          : sel_q;
  assign acc_wdata = capture ? wdata        : wdata_q;
  assign acc_wr    = capture ? mem_write    : wr_q;
  assign commit    = (state_d == S_RESP) && (state_q != S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= commit;
      if (capture) begin
        addr_q  <= addr[AW-1:0];
        sel_q   <= sel;
        wdata_q <= wdata;
        wr_q    <= mem_write;
      end
      if (commit) rdata_q <= acc_wr ? '0 : ram[acc_addr];
    end
  end

  // RAM has no reset; a request pending when reset hits is simply never committed.
  always_ff @(posedge clk) begin
    if (rst_n && commit && acc_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (acc_sel[b]) ram[acc_addr][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign unused_addr = ^addr[29:AW];
  assign rdata       = rdata_q;
  assign ack         = ack_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_furv_mem_responder.sv
// Bench for furv_mem_responder: four builds (LATENCY 1, 3, 0, 15) share the request
// bus; expected load/store responses are queued at issue and matched on each ack.
module tb_furv_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_write;
  logic [29:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        mem_v   [4];
  logic [31:0] rdata_v [4];
  logic        ack_v   [4];
  logic        busy_v  [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          dut;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mdl [4][1024];
  logic        prev_ack [4];

  always #5 clk = ~clk;

  furv_mem_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .mem(mem_v[0]), .mem_write(mem_write), .addr(addr),
    .sel(sel), .wdata(wdata), .rdata(rdata_v[0]), .ack(ack_v[0]), .busy(busy_v[0]));
  furv_mem_responder #(.DEPTH(1024), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .mem(mem_v[1]), .mem_write(mem_write), .addr(addr),
    .sel(sel), .wdata(wdata), .rdata(rdata_v[1]), .ack(ack_v[1]), .busy(busy_v[1]));
  furv_mem_responder #(.DEPTH(1024), .LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .mem(mem_v[2]), .mem_write(mem_write), .addr(addr),
    .sel(sel), .wdata(wdata), .rdata(rdata_v[2]), .ack(ack_v[2]), .busy(busy_v[2]));
  furv_mem_responder #(.DEPTH(1024), .LATENCY(15)) u_l15 (
    .clk(clk), .rst_n(rst_n), .mem(mem_v[3]), .mem_write(mem_write), .addr(addr),
    .sel(sel), .wdata(wdata), .rdata(rdata_v[3]), .ack(ack_v[3]), .busy(busy_v[3]));

  // Scoreboard monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ack_v[k] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack dut=%0d rdata=%h expected no ack", k, rdata_v[k]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.dut != k || rdata_v[k] !== e.data) begin
            errors++;
            $display("FAIL rdata dut=%0d got=%h expected dut=%0d data=%h", k, rdata_v[k], e.dut, e.data);
          end
        end
        checks++;
        if (prev_ack[k] === 1'b1) begin
          errors++;
          $display("FAIL ack_width dut=%0d ack high 2 cycles, expected 1", k);
        end
      end
      prev_ack[k] = ack_v[k];
    end
  end

  task automatic access(input int k, input int lat, input bit wr, input logic [29:0] a,
                        input logic [3:0] s, input logic [31:0] d, input bit scramble);
    exp_t e;
    int   n;
    bit   seen;
    e.dut = k;
    if (wr) begin
      e.data = '0;
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[k][a[9:0]][8*b +: 8] = d[8*b +: 8];
    end else begin
      e.data = mdl[k][a[9:0]];
    end
    exp_q.push_back(e);
    @(negedge clk);
    mem_v[k] = 1'b1; mem_write = wr; addr = a; sel = s; wdata = d;
    @(posedge clk);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (ack_v[k] === 1'b1) seen = 1'b1;
      else if (scramble) begin
        addr = 30'($urandom); sel = 4'($urandom); wdata = $urandom;
        mem_write = 1'($urandom); mem_v[k] = 1'($urandom);
      end
    end
    mem_v[k] = 1'b0;
    checks++;
    if (!seen || n != lat + 1) begin
      errors++;
      $display("FAIL latency dut=%0d got=%0d cycles (seen=%0d) expected=%0d", k, n, seen, lat + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) mem_v[k] = 1'b1;
    mem_write = 1'b0; addr = '0; sel = '0; wdata = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ack_v[k] !== 1'b0 || rdata_v[k] !== 32'h0 || busy_v[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut=%0d ack=%b rdata=%h busy=%b expected 0/0/0",
                 k, ack_v[k], rdata_v[k], busy_v[k]);
      end
    end
    for (int k = 0; k < 4; k++) mem_v[k] = 1'b0;
    rst_n = 1'b1;
    access(0, 1, 1'b0, 30'd0, 4'hF, 32'h0, 1'b0);
  endtask

  task automatic test_store_load();
    access(0, 1, 1'b1, 30'd4, 4'b1111, 32'hDEADBEEF, 1'b0);
    access(0, 1, 1'b0, 30'd4, 4'b0000, 32'h0, 1'b0);
    access(0, 1, 1'b1, 30'd4, 4'b0010, 32'h0000AA00, 1'b0);
    access(0, 1, 1'b0, 30'd4, 4'b0101, 32'h0, 1'b0);
    checks++;
    if (mdl[0][4] !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL model_merge got=%h expected=%h", mdl[0][4], 32'hDEADAAEF);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc [3];
    int   na;
    e.dut = 0; e.data = mdl[0][4];
    repeat (3) exp_q.push_back(e);
    na = 0;
    @(negedge clk);
    mem_v[0] = 1'b1; mem_write = 1'b0; addr = 30'd4; sel = 4'hF;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ack_v[0] === 1'b1) begin
        if (na < 3) cyc[na] = c;
        na++;
        if (na == 3) mem_v[0] = 1'b0;
      end else if (na > 0 && na <= 3 && c == cyc[na-1] + 1) begin
        checks++;
        if (busy_v[0] !== 1'b0) begin
          errors++;
          $display("FAIL turnaround cycle=%0d busy=%b expected 0", c, busy_v[0]);
        end
      end
    end
    mem_v[0] = 1'b0;
    checks++;
    if (na != 3) begin
      errors++;
      $display("FAIL b2b_count got=%0d expected=3", na);
    end else begin
      checks++;
      if (cyc[0] != 2 || cyc[1] - cyc[0] != 3 || cyc[2] - cyc[1] != 3) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d,%0d,%0d expected=2,5,8", cyc[0], cyc[1], cyc[2]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    mem_v[1] = 1'b1; mem_write = 1'b1; addr = 30'd8; sel = 4'hF; wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_v[1] !== 1'b1) begin
      errors++;
      $display("FAIL midop_busy got=%b expected 1", busy_v[1]);
    end
    rst_n = 1'b0;
    mem_v[1] = 1'b0;
    #1;
    checks++;
    if (busy_v[1] !== 1'b0 || ack_v[1] !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset busy=%b ack=%b expected 0/0", busy_v[1], ack_v[1]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    access(1, 3, 1'b0, 30'd8, 4'hF, 32'h0, 1'b0);
  endtask

  task automatic test_alias();
    access(0, 1, 1'b1, 30'd1028, 4'hF, 32'hCAFEF00D, 1'b0);
    access(0, 1, 1'b0, 30'd4, 4'hF, 32'h0, 1'b0);
    access(0, 1, 1'b1, 30'd4, 4'b0000, 32'hFFFFFFFF, 1'b0);
    access(0, 1, 1'b0, 30'd4, 4'hF, 32'h0, 1'b0);
    checks++;
    if (mdl[0][4] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL model_alias got=%h expected=%h", mdl[0][4], 32'hCAFEF00D);
    end
  endtask

  task automatic test_latency_builds();
    access(2, 0, 1'b1, 30'd12, 4'hF, 32'h11223344, 1'b0);
    access(2, 0, 1'b0, 30'd12, 4'hF, 32'h0, 1'b0);
    access(2, 0, 1'b1, 30'd12, 4'b1000, 32'h99000000, 1'b0);
    access(2, 0, 1'b0, 30'd12, 4'h0, 32'h0, 1'b0);
    access(3, 15, 1'b1, 30'd20, 4'hF, 32'hA5A55A5A, 1'b1);
    access(3, 15, 1'b0, 30'd20, 4'hF, 32'h0, 1'b1);
    access(3, 15, 1'b0, 30'd21, 4'hF, 32'h0, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      prev_ack[k] = 1'b0;
      for (int i = 0; i < 1024; i++) mdl[k][i] = '0;
    end
    test_reset();
    test_store_load();
    test_back_to_back();
    test_reset_mid_op();
    test_alias();
    test_latency_builds();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
